// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample width, channel encoding and the I2S receive states.
package audio_pkg;

  localparam int I2S_DATA_W = 24;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    PAD
  } rx_state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// Sample-pair handshake between the I2S receiver (master) and the synth/mixer consumer (slave).
interface i2s_rx_if
  import audio_pkg::*;
#(
  parameter int DATA_W = I2S_DATA_W
);

  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic              sample_valid;
  logic              sample_ready;
  logic              overflow;
  logic              frame_err;

  modport master (
    output sample_l,
    output sample_r,
    output sample_valid,
    output overflow,
    output frame_err,
    input  sample_ready
  );

  modport slave (
    input  sample_l,
    input  sample_r,
    input  sample_valid,
    input  overflow,
    input  frame_err,
    output sample_ready
  );

endinterface

// File: rtl/sig_sync.sv
// Multi-flop synchroniser for an asynchronous pad, with single-cycle rise/fall pulses on the synchronised level.
module sig_sync
  import audio_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver: follows external SCLK/LRCK, deserialises SDIN and presents one
// stereo pair per frame on a valid/ready handshake, flagging dropped pairs and short slots.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     sclk_in,
  input  logic     lrck_in,
  input  logic     sdin,
  i2s_rx_if.master rx
);

  localparam int CNT_W = $clog2(DATA_W);

  logic                   sclkS;
  logic                   bitEvent;
  logic                   lrckS;
  logic                   sdinS;
  logic [SYNC_STAGES-1:0] sdinSync_q;

  rx_state_t              state_q;
  logic [CNT_W-1:0]       bitCnt_q;
  logic                   chan_q;
  logic                   lrckPrev_q;
  logic [DATA_W-1:0]      shift_q;
  logic [DATA_W-1:0]      leftHold_q;
  logic                   leftValid_q;
  logic                   pairDone_q;
  logic                   frameErr_q;
  logic [DATA_W-1:0]      sampleL_q;
  logic [DATA_W-1:0]      sampleR_q;
  logic                   valid_q;
  logic                   overflow_q;

  logic [DATA_W-1:0]      word_d;
  logic                   lrckChg;

  sig_sync #(.STAGES(SYNC_STAGES)) uSclkSync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sclk_in),
    .q_o    (sclkS),
    .rise_o (bitEvent),
    .fall_o ()
  );

  sig_sync #(.STAGES(SYNC_STAGES)) uLrckSync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (lrck_in),
    .q_o    (lrckS),
    .rise_o (),
    .fall_o ()
  );

  // sdin goes through the same depth as sclk so it lines up with the bit event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdinSync_q <= '0;
    end else begin
      sdinSync_q <= {sdinSync_q[SYNC_STAGES-2:0], sdin};
    end
  end

  assign sdinS   = sdinSync_q[SYNC_STAGES-1];
  assign word_d  = {shift_q[DATA_W-2:0], sdinS};
  assign lrckChg = lrckS != lrckPrev_q;

  // The bit event on which LRCK is seen to change is itself the one-bit delay slot, so SKIP
  // means "delay consumed, MSB comes next" and handles the MSB exactly like SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      chan_q      <= LEFT;
      lrckPrev_q  <= 1'b0;
      shift_q     <= '0;
      leftHold_q  <= '0;
      leftValid_q <= 1'b0;
      pairDone_q  <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      pairDone_q <= 1'b0;
      frameErr_q <= 1'b0;
      if (bitEvent) begin
        lrckPrev_q <= lrckS;
        case (state_q)
          IDLE: begin
            if (lrckChg && (lrckS == LEFT)) begin
              chan_q   <= LEFT;
              bitCnt_q <= '0;
              state_q  <= SKIP;
            end
          end
          SKIP, SHIFT: begin
            if (lrckChg) begin
              frameErr_q <= 1'b1;
              if (chan_q == LEFT) begin
                leftValid_q <= 1'b0;
              end
              chan_q   <= lrckS;
              bitCnt_q <= '0;
              state_q  <= SKIP;
            end else begin
              shift_q <= word_d;
              if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
                if (chan_q == LEFT) begin
                  leftHold_q  <= word_d;
                  leftValid_q <= 1'b1;
                end else if (leftValid_q) begin
                  pairDone_q  <= 1'b1;
                  leftValid_q <= 1'b0;
                end
                state_q <= PAD;
              end else begin
                bitCnt_q <= bitCnt_q + 1'b1;
                state_q  <= SHIFT;
              end
            end
          end
          PAD: begin
            if (lrckChg) begin
              chan_q   <= lrckS;
              bitCnt_q <= '0;
              state_q  <= SKIP;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // The right word stays in shift_q until the next bit event, which is at least 4 clk away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sampleL_q  <= '0;
      sampleR_q  <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (pairDone_q) begin
        if (!valid_q || rx.sample_ready) begin
          sampleL_q <= leftHold_q;
          sampleR_q <= shift_q;
          valid_q   <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (valid_q && rx.sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.sample_l     = sampleL_q;
  assign rx.sample_r     = sampleR_q;
  assign rx.sample_valid = valid_q;
  assign rx.overflow     = overflow_q;
  assign rx.frame_err    = frameErr_q;

endmodule
